// File: rtl/coef_streamer.sv
// coef_streamer: buffers the 12 coefficients of a 3x4 matrix, then pulses cf_load and streams them one per cycle,
// holding the next cf_load off for FRAME_GAP cycles; COEF_STREAMER_PINGPONG_EN adds a second bank so filling overlaps sending.
module coef_streamer #(
  parameter int DATA_W    = 8,
  parameter int FRAME_GAP = 20
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cf_load,
  output logic [DATA_W-1:0] cf_data,
  output logic              busy,
  output logic              frame_done
);

  generate
    if (FRAME_GAP < 13 || FRAME_GAP > 63) begin : g_gap_check
      $error("coef_streamer: FRAME_GAP must be within 13..63");
    end
  endgenerate

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [5:0] LAST_CNT = 6'(FRAME_GAP - 1);

  logic [2:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [3:0]        wr_ptr_q, wr_ptr_d;
  logic [3:0]        rd_idx;
  logic              in_ready_q, in_ready_d;
  logic              cf_load_q, busy_q, frame_done_q;
  logic [DATA_W-1:0] cf_data_q, rd_word;
  logic              accept, wrap, frame_end, ready_d;

  assign accept    = in_valid & in_ready_q;
  assign wrap      = accept && (wr_ptr_q == 4'd11);
  assign frame_end = frame_done_q;
  assign wr_ptr_d  = wrap ? 4'd0 : (accept ? wr_ptr_q + 4'd1 : wr_ptr_q);
  assign rd_idx    = cnt_d[3:0] - 4'd1;

`ifdef COEF_STREAMER_PINGPONG_EN
  logic [DATA_W-1:0] bank_q [2][12];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;

  // Writer and reader never collide: the writer only reaches a bank once the reader has released it.
  always_comb begin
    full_d = full_q;
    if (frame_end) full_d[rd_bank_q] = 1'b0;
    if (wrap)      full_d[wr_bank_q] = 1'b1;
  end

  assign wr_bank_d  = wr_bank_q ^ wrap;
  assign rd_bank_d  = rd_bank_q ^ frame_end;
  assign ready_d    = full_d[rd_bank_d];
  assign in_ready_d = (state_d != S_IDLE) && !full_d[wr_bank_d];
  assign rd_word    = bank_q[rd_bank_q][rd_idx];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bank_q[wr_bank_q][wr_ptr_q] <= in_data;
  end
`else
  logic [DATA_W-1:0] bank_q [12];
  logic              full_q, full_d;

  assign full_d     = (full_q & ~frame_end) | wrap;
  assign ready_d    = full_d;
  assign in_ready_d = (state_d == S_FILL);
  assign rd_word    = bank_q[rd_idx];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) full_q <= 1'b0;
    else      full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    if (accept) bank_q[wr_ptr_q] <= in_data;
  end
`endif

  // cnt is the cycle index within a frame: 0 at LOAD, frame ends at FRAME_GAP-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: if (ready_d) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_SEND;
        cnt_d   = 6'd1;
      end
      S_SEND, S_GAP: begin
        cnt_d = cnt_q + 6'd1;
        if (frame_end) begin
          state_d = ready_d ? S_LOAD : S_FILL;
          cnt_d   = 6'd0;
        end else if (state_q == S_SEND && cnt_q == 6'd12) begin
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      in_ready_q   <= 1'b0;
      cf_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      in_ready_q   <= in_ready_d;
      cf_load_q    <= (state_d == S_LOAD);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_GAP);
      frame_done_q <= ((state_d == S_SEND) || (state_d == S_GAP)) && (cnt_d == LAST_CNT);
      cf_data_q    <= (state_d == S_SEND) ? rd_word : '0;
    end
  end

  assign in_ready   = in_ready_q;
  assign cf_load    = cf_load_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cf_data    = cf_data_q;

endmodule

// File: tb/tb_coef_streamer.sv
// Directed bench for coef_streamer: frame timing, handshake, reset mid-frame, FRAME_GAP=13 instance.
module tb_coef_streamer;

  logic       clk = 1'b0;
  logic       aclr, in_valid;
  logic [7:0] in_data;
  logic       in_ready, cf_load, busy, frame_done;
  logic [7:0] cf_data;
  logic       in_ready13, cf_load13, busy13, frame_done13;
  logic [7:0] cf_data13;

  int tests = 0;
  int fails = 0;
  int src_left = 0;

  always #5 clk = ~clk;

  coef_streamer #(.DATA_W(8), .FRAME_GAP(20)) dut (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cf_load(cf_load), .cf_data(cf_data),
    .busy(busy), .frame_done(frame_done)
  );

  coef_streamer #(.DATA_W(8), .FRAME_GAP(13)) dut13 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready13), .cf_load(cf_load13), .cf_data(cf_data13),
    .busy(busy13), .frame_done(frame_done13)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the upstream source advances to its next beat only when the beat was accepted.
  task automatic step();
    logic acc;
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (acc && src_left > 0) begin
      src_left--;
      if (src_left == 0) in_valid = 1'b0;
      else               in_data  = in_data + 8'd1;
    end
  endtask

  task automatic start_src(input logic [7:0] base, input int n);
    in_data  = base;
    in_valid = 1'b1;
    src_left = n;
  endtask

  task automatic wait_load(input string tag, output int n);
    n = 0;
    while (cf_load !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_load_timeout"}, 32'(n < 200), 32'd1);
  endtask

  // Starts in cycle 0 of a frame, ends in cycle 19.
  task automatic check_frame(input logic [7:0] base, input string tag);
    logic [7:0] exp;
    chk({tag, "_load_c0"}, cf_load, 1);
    chk({tag, "_busy_c0"}, busy, 1);
    chk({tag, "_data_c0"}, cf_data, 0);
    chk({tag, "_done_c0"}, frame_done, 0);
`ifndef COEF_STREAMER_PINGPONG_EN
    chk({tag, "_rdy_c0"}, in_ready, 0);
`endif
    for (int k = 1; k < 20; k++) begin
      step();
      exp = (k <= 12) ? base + 8'(k - 1) : 8'h00;
      chk($sformatf("%s_data_c%0d", tag, k), cf_data, exp);
      chk($sformatf("%s_load_c%0d", tag, k), cf_load, 0);
      chk($sformatf("%s_busy_c%0d", tag, k), busy, 1);
      chk($sformatf("%s_done_c%0d", tag, k), frame_done, 32'(k == 19));
`ifndef COEF_STREAMER_PINGPONG_EN
      chk($sformatf("%s_rdy_c%0d", tag, k), in_ready, 0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int accepts;
    aclr = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cf_load", cf_load, 0);
    chk("rst_cf_data", cf_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    aclr = 1'b0;
    chk("idle_in_ready", in_ready, 0);
    step();
    chk("fill_in_ready", in_ready, 1);

    // A: 12 back-to-back beats
    start_src(8'h01, 12);
    wait_load("A", n);
    chk("A_fill_cycles", n, 12);
    check_frame(8'h01, "A");
    step();
    chk("A_busy_c20", busy, 0);
    chk("A_rdy_c20", in_ready, 1);
    chk("A_load_c20", cf_load, 0);

    // B: valid every other cycle, garbage data while not valid
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      if (in_ready) accepts++;
      step();
      in_valid = 1'b0;
      in_data  = 8'hFF;
      if (i < 11) step();
    end
    chk("B_accepts", accepts, 12);
    check_frame(8'hA0, "B");
    step();
    chk("B_busy_c20", busy, 0);

`ifndef COEF_STREAMER_PINGPONG_EN
    // C: 24 beats queued, single bank stalls upstream for the whole frame
    start_src(8'h31, 24);
    wait_load("C1", n);
    chk("C1_fill_cycles", n, 12);
    check_frame(8'h31, "C1");
    step();
    chk("C_rdy_c20", in_ready, 1);
    chk("C_busy_c20", busy, 0);
    wait_load("C2", n);
    chk("C2_load_after_c20", n, 12);
    check_frame(8'h3D, "C2");
    step();
    chk("C2_busy_c20", busy, 0);
`else
    // C: 24 beats streamed, second frame exactly FRAME_GAP later
    start_src(8'h31, 24);
    wait_load("P1", n);
    chk("P1_fill_cycles", n, 12);
    check_frame(8'h31, "P1");
    step();
    check_frame(8'h3D, "P2");
    step();
    chk("P2_busy_c20", busy, 0);
    chk("P2_load_c20", cf_load, 0);
`endif

    // D: reset in SEND cycle 6, then reset again after a partial fill
    start_src(8'h50, 12);
    wait_load("D0", n);
    chk("D0_fill_cycles", n, 12);
    for (int k = 0; k < 6; k++) step();
    chk("D0_data_c6", cf_data, 8'h55);
    aclr = 1'b1;
    #1;
    chk("D_async_data", cf_data, 0);
    chk("D_async_busy", busy, 0);
    chk("D_async_load", cf_load, 0);
    chk("D_async_rdy", in_ready, 0);
    @(posedge clk); #1;
    aclr = 1'b0;
    step();
    chk("D_refill_rdy", in_ready, 1);
    start_src(8'h99, 5);
    for (int k = 0; k < 5; k++) step();
    aclr = 1'b1;
    #1;
    chk("D_partial_rst_rdy", in_ready, 0);
    @(posedge clk); #1;
    aclr = 1'b0;
    step();
    start_src(8'h60, 12);
    wait_load("D1", n);
    chk("D1_fill_cycles", n, 12);
    check_frame(8'h60, "D1");
    step();
    chk("D1_busy_c20", busy, 0);

    // E: FRAME_GAP=13 instance, frame_done coincides with the last coefficient
    aclr = 1'b1;
    @(posedge clk); #1;
    aclr = 1'b0;
    step();
    start_src(8'h70, 12);
    wait_load("E", n);
    chk("E_load13_c0", cf_load13, 1);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("E_data13_c%0d", k), cf_data13, (k <= 12) ? 8'h70 + 8'(k - 1) : 8'h00);
      chk($sformatf("E_done13_c%0d", k), frame_done13, 32'(k == 12));
      chk($sformatf("E_busy13_c%0d", k), busy13, 32'(k <= 12));
    end
    chk("E_rdy13_c13", in_ready13, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
